// File: rtl/tff_edge_counter.sv
// tff_edge_counter: modulo-MOD up/down counter of rising edges seen on a toggle-stage output.
// Define TFF_EDGE_COUNTER_LOAD_EN to enable the clamped parallel load; otherwise load/din are ignored.
module tff_edge_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_in,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_b,
    output logic             edge_seen,
    output logic             wrap,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    generate
        if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
            $error("tff_edge_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
        end
    endgenerate

    logic             t_prev;
    logic             edge_det;
    logic             load_hit;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count_next;
    logic             edge_seen_next;
    logic             wrap_next;

    assign edge_det = t_in & ~t_prev;

`ifdef TFF_EDGE_COUNTER_LOAD_EN
    // Out-of-range load values saturate at the top of the count range.
    assign load_hit = load;
    assign load_val = (din > LAST) ? LAST : din;
`else
    logic unused_load;
    assign unused_load = ^{load, din};
    assign load_hit    = 1'b0;
    assign load_val    = ZERO;
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        count_next     = count;
        edge_seen_next = 1'b0;
        wrap_next      = 1'b0;
        if (load_hit) begin
            count_next = load_val;
        end else if (edge_det && en) begin
            edge_seen_next = 1'b1;
            if (up) begin
                if (count == LAST) begin
                    count_next = ZERO;
                    wrap_next  = 1'b1;
                end else begin
                    count_next = count + ONE;
                end
            end else begin
                if (count == ZERO) begin
                    count_next = LAST;
                    wrap_next  = 1'b1;
                end else begin
                    count_next = count - ONE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        // t_prev tracks t_in even in reset, so a level held high across release is not an edge.
        t_prev <= t_in;
        if (rst) begin
            count     <= ZERO;
            count_b   <= '1;
            edge_seen <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            count     <= count_next;
            count_b   <= ~count_next;
            edge_seen <= edge_seen_next;
            wrap      <= wrap_next;
        end
    end

    assign tc = up ? (count == LAST) : (count == ZERO);

endmodule

// File: tb/tb_tff_edge_counter.sv
// Directed bench for tff_edge_counter (WIDTH=4, MOD=10); expectations queued at drive time, checked after the edge.
// Load expectations follow TFF_EDGE_COUNTER_LOAD_EN when the bench is compiled with it.
module tb_tff_edge_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       t_in = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] din = 4'd0;
    logic [3:0] count;
    logic [3:0] count_b;
    logic       edge_seen;
    logic       wrap;
    logic       tc;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        string      tag;
        logic [3:0] cnt;
        logic       es;
        logic       wr;
    } exp_t;

    exp_t sb[$];

    tff_edge_counter #(.WIDTH(4), .MOD(10)) dut (
        .clk(clk), .rst(rst), .t_in(t_in), .en(en), .up(up), .load(load), .din(din),
        .count(count), .count_b(count_b), .edge_seen(edge_seen), .wrap(wrap), .tc(tc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input logic r, input logic t, input logic e, input logic u,
                        input logic ld, input logic [3:0] d,
                        input logic [3:0] c, input logic es, input logic wr, input string tag);
        exp_t x;
        logic [3:0] exp_b;
        logic       exp_tc;
        @(negedge clk);
        rst = r; t_in = t; en = e; up = u; load = ld; din = d;
        sb.push_back('{tag, c, es, wr});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        exp_b  = ~x.cnt;
        exp_tc = (up && x.cnt == 4'd9) || (!up && x.cnt == 4'd0);
        n_checks++;
        assert (count === x.cnt) else begin
            n_fails++;
            $error("FAIL %s count: observed %0d expected %0d", x.tag, count, x.cnt);
        end
        n_checks++;
        assert (count_b === exp_b) else begin
            n_fails++;
            $error("FAIL %s count_b: observed %b expected %b", x.tag, count_b, exp_b);
        end
        n_checks++;
        assert (edge_seen === x.es) else begin
            n_fails++;
            $error("FAIL %s edge_seen: observed %b expected %b", x.tag, edge_seen, x.es);
        end
        n_checks++;
        assert (wrap === x.wr) else begin
            n_fails++;
            $error("FAIL %s wrap: observed %b expected %b", x.tag, wrap, x.wr);
        end
        n_checks++;
        assert (tc === exp_tc) else begin
            n_fails++;
            $error("FAIL %s tc: observed %b expected %b", x.tag, tc, exp_tc);
        end
    endtask

    initial begin
        // Reset with t_in high through release: no spurious edge.
        step(1, 1, 0, 1, 0, 0, 4'd0, 0, 0, "reset_a");
        step(1, 1, 1, 1, 0, 0, 4'd0, 0, 0, "reset_b");
        step(0, 1, 1, 1, 0, 0, 4'd0, 0, 0, "release_no_edge");

        // Three rising edges counting up.
        step(0, 0, 1, 1, 0, 0, 4'd0, 0, 0, "up_low1");
        step(0, 1, 1, 1, 0, 0, 4'd1, 1, 0, "up_edge1");
        step(0, 0, 1, 1, 0, 0, 4'd1, 0, 0, "up_low2");
        step(0, 1, 1, 1, 0, 0, 4'd2, 1, 0, "up_edge2");
        step(0, 0, 1, 1, 0, 0, 4'd2, 0, 0, "up_low3");
        step(0, 1, 1, 1, 0, 0, 4'd3, 1, 0, "up_edge3");
        step(0, 1, 1, 1, 0, 0, 4'd3, 0, 0, "held_high");

        // Count on to 9 (tc=1), then wrap to 0.
        for (int k = 4; k <= 9; k++) begin
            step(0, 0, 1, 1, 0, 0, 4'(k - 1), 0, 0, "climb_low");
            step(0, 1, 1, 1, 0, 0, 4'(k), 1, 0, "climb_edge");
        end
        step(0, 0, 1, 1, 0, 0, 4'd9, 0, 0, "at_nine");
        step(0, 1, 1, 1, 0, 0, 4'd0, 1, 1, "up_wrap");
        step(0, 0, 1, 1, 0, 0, 4'd0, 0, 0, "up_wrap_clear");

        // Down wrap 0 -> 9, then 9 -> 8 without wrap.
        step(0, 0, 1, 0, 0, 0, 4'd0, 0, 0, "down_at_zero");
        step(0, 1, 1, 0, 0, 0, 4'd9, 1, 1, "down_wrap");
        step(0, 0, 1, 0, 0, 0, 4'd9, 0, 0, "down_wrap_clear");
        step(0, 1, 1, 0, 0, 0, 4'd8, 1, 0, "down_eight");

        // Edges with en=0 are dropped, and enabling with t_in high adds nothing.
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 0, 4'd8, 0, 0, "gated_low");
            step(0, 1, 0, 0, 0, 0, 4'd8, 0, 0, "gated_high");
        end
        step(0, 1, 1, 0, 0, 0, 4'd8, 0, 0, "no_late_a");
        step(0, 1, 1, 0, 0, 0, 4'd8, 0, 0, "no_late_b");

        // Down to 6, then reset coincident with an edge.
        step(0, 0, 1, 0, 0, 0, 4'd8, 0, 0, "to6_low1");
        step(0, 1, 1, 0, 0, 0, 4'd7, 1, 0, "to6_edge1");
        step(0, 0, 1, 0, 0, 0, 4'd7, 0, 0, "to6_low2");
        step(0, 1, 1, 0, 0, 0, 4'd6, 1, 0, "to6_edge2");
        step(0, 0, 1, 0, 0, 0, 4'd6, 0, 0, "at_six");
        step(1, 1, 1, 0, 0, 0, 4'd0, 0, 0, "rst_mid");
        step(0, 1, 1, 1, 0, 0, 4'd0, 0, 0, "rst_mid_release");

        // Load coincident with an edge, then an out-of-range load, then an edge from 9.
        step(0, 0, 1, 1, 0, 0, 4'd0, 0, 0, "pre_load");
`ifdef TFF_EDGE_COUNTER_LOAD_EN
        step(0, 1, 1, 1, 1, 4'd7,  4'd7, 0, 0, "load_over_edge");
        step(0, 0, 1, 1, 1, 4'd12, 4'd9, 0, 0, "load_clamp");
        step(0, 1, 1, 1, 0, 0,     4'd0, 1, 1, "post_load_wrap");
`else
        step(0, 1, 1, 1, 1, 4'd7,  4'd1, 1, 0, "load_ignored_edge");
        step(0, 0, 1, 1, 1, 4'd12, 4'd1, 0, 0, "load_ignored_clamp");
        step(0, 1, 1, 1, 0, 0,     4'd2, 1, 0, "post_load_edge");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
